phase_accumulator: RTL
======================

Name: phase_accumulator

Overview:
- Numerically controlled oscillator (NCO) front end for the synth voice.
- Produces the table/waveform read address `addr_r` consumed by the waveform stages (square, saw, sine LUTs) at a fixed audio sample rate derived from `clk`.
- Pitch is set by a tuning word loaded over a ready/valid handshake, applied either immediately or phase-coherently at cycle wrap.
- Emits a sample strobe aligned to the 1-cycle registered waveform output.

Parameters:
- ACC_WIDTH, 24, phase accumulator width; tuning word width.
- ADDR_WIDTH, 8, output address width; `addr_r` = acc[ACC_WIDTH-1 -: ADDR_WIDTH].
- CLK_DIV, 1042, clk cycles per sample tick (100 MHz / ~96 kHz); legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run oscillator; low = freeze phase, no ticks.
- phase_sync  in  1  single-cycle note-on pulse: restart phase at 0.
- apply_on_wrap  in  1  0 = apply new word at next tick; 1 = apply at next accumulator wrap.
- tw_valid  in  1  tuning word valid.
- tw_ready  out  1  block can accept a tuning word.
- tw_data  in  ACC_WIDTH  tuning word (phase increment per tick).
- addr_r  out  ADDR_WIDTH  waveform read address.
- addr_valid  out  1  1-cycle pulse, `addr_r` just updated.
- sample_valid  out  1  `addr_valid` delayed 1 cycle, aligned to registered LUT dout.
- wrap  out  1  1-cycle pulse, coincident with `addr_valid`, when the update overflowed.

Behaviour:
- Reset (async assert, sync release):
  - acc, tw_active, divider = 0.
  - Pending flag cleared; `tw_ready` = 1.
  - `addr_r` = 0; `addr_valid`, `sample_valid`, `wrap` = 0.
- Divider:
  - When `enable` = 1, the counter runs 0..CLK_DIV-1; `tick` is internal and asserts when the count = CLK_DIV-1, after which the count returns to 0.
  - When `enable` = 0, the counter is held at 0 and there are no ticks.
  - CLK_DIV = 1 gives a tick every enabled cycle.
- Tick edge:
  - acc <= acc + tw_active, modulo 2^ACC_WIDTH.
  - Carry out registers `wrap` = 1 for the next cycle.
  - `addr_valid` = 1 for the next cycle; `addr_r` is the top bits of the acc register, so its new value is visible in the same cycle as `addr_valid`.
  - `sample_valid` = `addr_valid` delayed one clk.
- Tuning handshake:
  - Transfer occurs on `tw_valid` && `tw_ready`: `tw_data` is captured into the pending register, pending is set, and `tw_ready` is 0 from the next cycle.
  - `tw_data` is ignored while `tw_ready` = 0. The source must hold the word; none is lost.
- Apply point (`apply_on_wrap` is sampled at the apply point):
  - Mode 0: at the next tick edge, tw_active <= pending. That tick's add still uses the old tw_active, so the new word takes effect from the following tick.
  - Mode 1: applies at the first tick edge whose add carries out.
  - On apply, pending clears and `tw_ready` = 1 the following cycle.
- phase_sync (highest priority, works even with `enable` = 0):
  - acc <= 0 and divider <= 0.
  - If pending is set, it is applied immediately and cleared.
  - `addr_valid` is pulsed with `addr_r` = 0; `wrap` is not pulsed.
  - A tick in the same cycle is discarded.
- enable = 0:
  - acc and tw_active are held; no strobes.
  - Handshake capture still works; pending waits until the next apply point.
- tw_active = 0: phase is frozen but strobes continue every tick.
- Async reset mid-operation: all outputs go to reset values immediately, without a clock edge; any pending word is discarded.

Test Plan:
- Basic ramp:
  - Stimulus: CLK_DIV=4; rst; enable=0; load 0x010000; pulse phase_sync; enable=1.
  - Response: `addr_r` 0x01, 0x02, … every 4 clk; `addr_valid` every 4th cycle; `sample_valid` 1 cycle later; 256th tick gives `addr_r`=0x00 with `wrap`=1.
- Half-rate word:
  - Stimulus: tw_active=0x800000 from phase 0.
  - Response: `addr_r` alternates 0x80, 0x00; `wrap` on every second tick (a downstream square stage toggles each tick).
- Wrap-coherent retune:
  - Stimulus: active 0x010000, `addr_r`=0xF0; load 0x020000 with apply_on_wrap=1.
  - Response: steps of 1 through 0xFF; the wrap tick gives 0x00; later steps 0x02, 0x04…; `tw_ready`=0 until the cycle after the wrap tick.
- Backpressure:
  - Stimulus: drive tw_valid continuously with words A then B, apply_on_wrap=0.
  - Response: B accepted only once `tw_ready` returns after A's apply tick; B is applied at the following tick; no word dropped or duplicated.
- Enable gap:
  - Stimulus: drop enable mid-count for 10 clk, then re-raise.
  - Response: no strobes; `addr_r` unchanged; first tick exactly CLK_DIV cycles after re-enable.
- Reset and sync corners:
  - Stimulus: assert rst_n low between clocks; separately, phase_sync coincident with a tick.
  - Response: reset clears all outputs asynchronously; phase_sync gives `addr_r`=0x00, `addr_valid`=1, `wrap`=0, with the tick discarded.

Source files
------------

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator with tick divider and tuning-word handshake
module phase_accumulator #(
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int CLK_DIV    = 1042
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  phase_sync,
    input  logic                  apply_on_wrap,
    input  logic                  tw_valid,
    output logic                  tw_ready,
    input  logic [ACC_WIDTH-1:0]  tw_data,
    output logic [ADDR_WIDTH-1:0] addr_r,
    output logic                  addr_valid,
    output logic                  sample_valid,
    output logic                  wrap
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] tw_active_q, tw_active_d;
    logic [ACC_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 addr_valid_q, addr_valid_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 wrap_q, wrap_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 tick;
    logic                 accept;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, tw_active_q};
        tick   = enable && (div_q == DIV_LAST);
        accept = tw_valid && !pend_valid_q;

        acc_d          = acc_q;
        tw_active_d    = tw_active_q;
        pend_data_d    = pend_data_q;
        pend_valid_d   = pend_valid_q;
        div_d          = (!enable || tick) ? '0 : div_q + DIV_W'(1);
        addr_valid_d   = 1'b0;
        wrap_d         = 1'b0;
        sample_valid_d = addr_valid_q;

        // Accept and apply are mutually exclusive: accept needs pending empty, apply needs it full.
        if (accept) begin
            pend_data_d  = tw_data;
            pend_valid_d = 1'b1;
        end

        if (phase_sync) begin
            acc_d        = '0;
            div_d        = '0;
            addr_valid_d = 1'b1;
            if (pend_valid_q) begin
                tw_active_d  = pend_data_q;
                pend_valid_d = 1'b0;
            end
        end else if (tick) begin
            acc_d        = sum[ACC_WIDTH-1:0];
            wrap_d       = sum[ACC_WIDTH];
            addr_valid_d = 1'b1;
            // The add above still uses the old word; the new one counts from the next tick.
            if (pend_valid_q && (!apply_on_wrap || sum[ACC_WIDTH])) begin
                tw_active_d  = pend_data_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            tw_active_q    <= '0;
            pend_data_q    <= '0;
            pend_valid_q   <= 1'b0;
            div_q          <= '0;
            addr_valid_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            tw_active_q    <= tw_active_d;
            pend_data_q    <= pend_data_d;
            pend_valid_q   <= pend_valid_d;
            div_q          <= div_d;
            addr_valid_q   <= addr_valid_d;
            sample_valid_q <= sample_valid_d;
            wrap_q         <= wrap_d;
        end
    end

    assign tw_ready     = !pend_valid_q;
    assign addr_r       = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
    assign addr_valid   = addr_valid_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;

endmodule
